// File: rtl/guess_pkg.sv
// guess_pkg: shared types and constants for the guess-checking game stage.
//   state_t   : game FSM states
//   HINT_*    : hint output codes
//   DIGITS_DEFAULT, BCD_MAX : default digit count and largest legal BCD digit
//   clamp_bcd : forces any nibble above 9 down to 9
package guess_pkg;

  localparam int         DIGITS_DEFAULT = 4;
  localparam logic [3:0] BCD_MAX        = 4'd9;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARMED = 3'd1,
    ST_CHECK = 3'd2,
    ST_WIN   = 3'd3,
    ST_LOSE  = 3'd4
  } state_t;

  localparam logic [1:0] HINT_NONE = 2'b00;
  localparam logic [1:0] HINT_LOW  = 2'b01;
  localparam logic [1:0] HINT_HIGH = 2'b10;
  localparam logic [1:0] HINT_EQ   = 2'b11;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    clamp_bcd = (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cmp.sv
// bcd_digit_cmp: combinational compare of one guess digit against one secret
// digit. Both nibbles are clamped to 9 before comparing.
//   guess_digit, secret_digit : BCD nibbles
//   eq / lt / gt              : guess equal to / below / above secret
module bcd_digit_cmp
  import guess_pkg::*;
(
  input  logic [3:0] guess_digit,
  input  logic [3:0] secret_digit,
  output logic       eq,
  output logic       lt,
  output logic       gt
);

  logic [3:0] guess_s;
  logic [3:0] secret_s;

  // Clamp both digits and derive the three relations
  always_comb begin
    guess_s  = clamp_bcd(guess_digit);
    secret_s = clamp_bcd(secret_digit);
    eq       = (guess_s == secret_s);
    lt       = (guess_s <  secret_s);
    gt       = (guess_s >  secret_s);
  end

endmodule

// File: rtl/guess_checker.sv
// guess_checker: compares a submitted BCD guess against a latched secret,
// one digit per cycle from the MSB, and reports hint, bull count, remaining
// trials and a sticky win/lose status.
//   clk, rst          : clock and synchronous active-high reset
//   start             : load secret/trial budget and arm (priority in all states)
//   secret, trials_in : values latched on start
//   submit, guess     : evaluate guess (accepted only in ARMED, not with start)
//   hint, bulls       : magnitude hint and exact-position matches
//   trials_left       : remaining trials
//   busy, done        : comparison in progress / one-cycle result strobe
//   win, lose         : sticky terminal status
module guess_checker
  import guess_pkg::*;
#(
  parameter int DIGITS   = DIGITS_DEFAULT,
  parameter int TRIALS_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*DIGITS-1:0]   secret,
  input  logic [TRIALS_W-1:0]   trials_in,
  input  logic                  submit,
  input  logic [4*DIGITS-1:0]   guess,
  output logic [1:0]            hint,
  output logic [2:0]            bulls,
  output logic [TRIALS_W-1:0]   trials_left,
  output logic                  busy,
  output logic                  done,
  output logic                  win,
  output logic                  lose
);

  localparam int                  IDX_W       = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0]    IDX_LAST    = IDX_W'(DIGITS - 1);
  localparam logic [IDX_W-1:0]    IDX_ZERO    = IDX_W'(0);
  localparam logic [IDX_W-1:0]    IDX_ONE     = IDX_W'(1);
  localparam logic [TRIALS_W-1:0] TRIALS_ZERO = TRIALS_W'(0);
  localparam logic [TRIALS_W-1:0] TRIALS_ONE  = TRIALS_W'(1);

  state_t           state_r;
  logic [IDX_W-1:0] idx_r;
  logic [3:0]       secret_dig_r [DIGITS];
  logic [3:0]       guess_dig_r  [DIGITS];
  logic [2:0]       bull_acc_r;
  logic [1:0]       mag_r;

  logic [3:0]          secret_clamp_s [DIGITS];
  logic [3:0]          guess_clamp_s  [DIGITS];
  logic [3:0]          guess_sel_s;
  logic [3:0]          secret_sel_s;
  logic                dig_eq_s;
  logic                dig_lt_s;
  logic                dig_gt_s;
  logic [2:0]          bulls_next_s;
  logic [1:0]          mag_next_s;
  logic [1:0]          hint_final_s;
  logic [TRIALS_W-1:0] trials_dec_s;
  logic [TRIALS_W-1:0] trials_load_s;

  // Split the input words into clamped per-digit arrays for latching
  always_comb begin
    for (int i = 0; i < DIGITS; i++) begin
      secret_clamp_s[i] = clamp_bcd(secret[4*i +: 4]);
      guess_clamp_s[i]  = clamp_bcd(guess[4*i +: 4]);
    end
  end

  // Select the digit pair under comparison this cycle
  always_comb begin
    guess_sel_s  = guess_dig_r[idx_r];
    secret_sel_s = secret_dig_r[idx_r];
  end

  bcd_digit_cmp u_cmp (
    .guess_digit  (guess_sel_s),
    .secret_digit (secret_sel_s),
    .eq           (dig_eq_s),
    .lt           (dig_lt_s),
    .gt           (dig_gt_s)
  );

  // Running bull count, first-difference magnitude and trial arithmetic
  always_comb begin
    if (dig_eq_s) begin
      bulls_next_s = bull_acc_r + 3'd1;
    end else begin
      bulls_next_s = bull_acc_r;
    end

    // Once a more-significant digit differed, lower digits cannot change the hint
    if (mag_r != HINT_NONE) begin
      mag_next_s = mag_r;
    end else if (dig_lt_s) begin
      mag_next_s = HINT_LOW;
    end else if (dig_gt_s) begin
      mag_next_s = HINT_HIGH;
    end else begin
      mag_next_s = HINT_NONE;
    end

    // No difference found across all digits means an exact match
    if (mag_next_s == HINT_NONE) begin
      hint_final_s = HINT_EQ;
    end else begin
      hint_final_s = mag_next_s;
    end

    if (trials_left == TRIALS_ZERO) begin
      trials_dec_s = TRIALS_ZERO;
    end else begin
      trials_dec_s = trials_left - TRIALS_ONE;
    end

    // A zero budget would end the game before any guess; grant one trial
    if (trials_in == TRIALS_ZERO) begin
      trials_load_s = TRIALS_ONE;
    end else begin
      trials_load_s = trials_in;
    end
  end

  // Game FSM with registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      idx_r       <= IDX_ZERO;
      bull_acc_r  <= 3'd0;
      mag_r       <= HINT_NONE;
      hint        <= HINT_NONE;
      bulls       <= 3'd0;
      trials_left <= TRIALS_ZERO;
      busy        <= 1'b0;
      done        <= 1'b0;
      win         <= 1'b0;
      lose        <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        secret_dig_r[i] <= 4'd0;
        guess_dig_r[i]  <= 4'd0;
      end
    end else begin
      done <= 1'b0;
      if (start) begin
        // start wins everywhere, including mid-compare; no done for an aborted guess
        for (int i = 0; i < DIGITS; i++) begin
          secret_dig_r[i] <= secret_clamp_s[i];
        end
        trials_left <= trials_load_s;
        hint        <= HINT_NONE;
        bulls       <= 3'd0;
        win         <= 1'b0;
        lose        <= 1'b0;
        busy        <= 1'b0;
        state_r     <= ST_ARMED;
      end else begin
        case (state_r)
          ST_IDLE: begin
            state_r <= ST_IDLE;
          end
          ST_ARMED: begin
            if (submit) begin
              for (int i = 0; i < DIGITS; i++) begin
                guess_dig_r[i] <= guess_clamp_s[i];
              end
              idx_r      <= IDX_LAST;
              bull_acc_r <= 3'd0;
              mag_r      <= HINT_NONE;
              busy       <= 1'b1;
              state_r    <= ST_CHECK;
            end
          end
          ST_CHECK: begin
            if (idx_r == IDX_ZERO) begin
              hint        <= hint_final_s;
              bulls       <= bulls_next_s;
              trials_left <= trials_dec_s;
              busy        <= 1'b0;
              done        <= 1'b1;
              if (hint_final_s == HINT_EQ) begin
                win     <= 1'b1;
                state_r <= ST_WIN;
              end else if (trials_dec_s == TRIALS_ZERO) begin
                lose    <= 1'b1;
                state_r <= ST_LOSE;
              end else begin
                state_r <= ST_ARMED;
              end
            end else begin
              bull_acc_r <= bulls_next_s;
              mag_r      <= mag_next_s;
              idx_r      <= idx_r - IDX_ONE;
            end
          end
          ST_WIN, ST_LOSE: begin
            state_r <= state_r;
          end
          default: begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_guess_checker.sv
// tb_guess_checker: directed self-checking bench for guess_checker.
module tb_guess_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] secret;
  logic [3:0]  trials_in;
  logic        submit;
  logic [15:0] guess;
  logic [1:0]  hint;
  logic [2:0]  bulls;
  logic [3:0]  trials_left;
  logic        busy;
  logic        done;
  logic        win;
  logic        lose;

  int tests_run = 0;
  int fail_cnt  = 0;

  guess_checker #(.DIGITS(4), .TRIALS_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .secret      (secret),
    .trials_in   (trials_in),
    .submit      (submit),
    .guess       (guess),
    .hint        ( hint ),
    .bulls       (bulls),
    .trials_left (trials_left),
    .busy        (busy),
    .done        (done),
    .win         (win),
    .lose        (lose)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_game(input logic [15:0] s, input logic [3:0] t);
    start     = 1'b1;
    secret    = s;
    trials_in = t;
    tick();
    start     = 1'b0;
    secret    = 16'h0000;
    trials_in = 4'd7;
  endtask

  // Count busy cycles after E0 (bounded); lands in the cycle after E4
  task automatic wait_result(input string tag);
    int n = 0;
    while (busy === 1'b1 && n < 10) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, 4);
    check({tag, "_done"}, done, 1);
  endtask

  task automatic do_guess(input string tag, input logic [15:0] g);
    submit = 1'b1;
    guess  = g;
    tick();
    submit = 1'b0;
    guess  = 16'hFFFF;
    check({tag, "_busy_e0"}, busy, 1);
    check({tag, "_done_e0"}, done, 0);
    wait_result(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_hint"}, hint, 0);
    check({tag, "_bulls"}, bulls, 0);
    check({tag, "_trials"}, trials_left, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_win"}, win, 0);
    check({tag, "_lose"}, lose, 0);
  endtask

  initial begin
    int done_seen;
    rst = 1'b1; start = 1'b0; submit = 1'b0;
    secret = 16'h0000; guess = 16'h0000; trials_in = 4'd0;
    repeat (2) tick();
    rst = 1'b0;
    check_reset_vals("reset");

    // submit in IDLE is ignored
    submit = 1'b1; guess = 16'h1234;
    tick();
    submit = 1'b0;
    check("idle_submit_busy", busy, 0);
    tick();
    check("idle_submit_done", done, 0);
    check("idle_submit_trials", trials_left, 0);

    // win with one trial left, second guess back-to-back at E5
    start_game(16'h1234, 4'd3);
    check("win_load_trials", trials_left, 3);
    check("win_load_busy", busy, 0);
    do_guess("g1", 16'h1250);
    check("g1_hint", hint, 2'b10);
    check("g1_bulls", bulls, 2);
    check("g1_trials", trials_left, 2);
    check("g1_win", win, 0);
    do_guess("g2", 16'h1234);
    check("g2_hint", hint, 2'b11);
    check("g2_bulls", bulls, 4);
    check("g2_trials", trials_left, 1);
    check("g2_win", win, 1);
    check("g2_lose", lose, 0);
    tick();
    check("g2_done_once", done, 0);
    submit = 1'b1; guess = 16'h0000;
    tick();
    submit = 1'b0;
    tick();
    check("win_hold_busy", busy, 0);
    check("win_hold_trials", trials_left, 1);
    check("win_hold_win", win, 1);

    // lose on last trial
    start_game(16'h5000, 4'd1);
    check("lose_load_win_clr", win, 0);
    check("lose_load_hint_clr", hint, 0);
    check("lose_load_trials", trials_left, 1);
    do_guess("g3", 16'h4999);
    check("g3_hint", hint, 2'b01);
    check("g3_bulls", bulls, 0);
    check("g3_trials", trials_left, 0);
    check("g3_lose", lose, 1);
    check("g3_win", win, 0);
    submit = 1'b1; guess = 16'h5000;
    tick();
    submit = 1'b0;
    tick();
    check("lose_hold_busy", busy, 0);
    check("lose_hold_hint", hint, 2'b01);
    check("lose_hold_lose", lose, 1);

    // clamping of secret, guess and zero trial budget
    start_game(16'hF9F0, 4'd0);
    check("clamp_trials", trials_left, 1);
    check("clamp_lose_clr", lose, 0);
    do_guess("g4", 16'h99A0);
    check("g4_hint", hint, 2'b11);
    check("g4_bulls", bulls, 4);
    check("g4_win", win, 1);
    check("g4_trials", trials_left, 0);

    // abort at E2 by start with a coincident submit
    start_game(16'h1111, 4'd4);
    submit = 1'b1; guess = 16'h2222;
    tick();
    submit = 1'b0;
    tick();
    start = 1'b1; secret = 16'h3333; trials_in = 4'd6;
    submit = 1'b1; guess = 16'h3333;
    tick();
    start = 1'b0; submit = 1'b0; secret = 16'h0000; trials_in = 4'd7;
    check("abort_busy", busy, 0);
    check("abort_trials", trials_left, 6);
    check("abort_hint", hint, 0);
    done_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (done === 1'b1 || busy === 1'b1) done_seen++;
      tick();
    end
    check("abort_no_done", done_seen, 0);
    do_guess("g5", 16'h3333);
    check("g5_hint", hint, 2'b11);
    check("g5_trials", trials_left, 5);
    check("g5_win", win, 1);

    // submit during busy is ignored; the first guess result stands
    start_game(16'h0000, 4'd5);
    submit = 1'b1; guess = 16'h0001;
    tick();
    submit = 1'b0; guess = 16'hFFFF;
    tick();
    submit = 1'b1; guess = 16'h0000;
    tick();
    submit = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (done === 1'b1) break;
      done_seen++;
      tick();
    end
    check("busy_sub_latency", done_seen, 2);
    check("busy_sub_hint", hint, 2'b10);
    check("busy_sub_bulls", bulls, 3);
    check("busy_sub_trials", trials_left, 4);
    tick();
    check("busy_sub_no_rerun", busy, 0);

    // reset mid-CHECK
    submit = 1'b1; guess = 16'h0000;
    tick();
    submit = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_vals("rst_mid");

    $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
    $finish;
  end

endmodule
